sort_datapath: RTL

- Datapath for the in-place K-entry exchange sorter. It is driven directly by the sorter FSM's control outputs (Li, Ei, Lj, Ej, EA, EB, Bout, Csel, Wr) and returns the status flags AgtB, zi and zj.
- Contains:
  - the K x DW data memory
  - outer index counter i and inner index counter j
  - operand registers A and B
  - an unsigned magnitude comparator
  - the address and write-data muxes
- A host port loads unsorted data and reads sorted results while the sorter is idle or done.

---
 rtl/sort_datapath.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sort_datapath.sv
// ---------------------------------------------------------------------------
// sort_datapath
//
// Datapath of the in-place K-entry exchange sorter. The sorter controller
// drives one control vector per cycle and this block reacts with one-edge
// latency for every state element. Holds the K x DW data memory, the outer
// (i) and inner (j) index counters, the operand registers A and B and an
// unsigned comparator. A host port loads unsorted data and reads back
// results while the engine is idle.
//
// Ports
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   Li, Ei       i <= 0 / i <= i+1 (wraps at K-1); Li wins
//   Lj, Ej       j <= i+1 (from pre-edge i, wraps) / j <= j+1 (wraps); Lj wins
//   EA, EB       A / B <= M[addr]
//   Bout         engine write data: 1 = B, 0 = A
//   Csel         engine address:    1 = j, 0 = i
//   Wr           engine write strobe (ignored while host_sel=1)
//   AgtB         A > B, unsigned
//   zi, zj       i == K-2, j == K-1
//   host_sel     1 = host owns the memory write port
//   host_we      host write strobe (ignored while host_sel=0)
//   host_addr    host address; addresses >= K are out of range
//   host_wdata   host write data
//   host_rdata   M[host_addr], combinational; 0 when out of range
// ---------------------------------------------------------------------------
module sort_datapath #(
    parameter int K  = 16,
    parameter int DW = 8,
    parameter int AW = $clog2(K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Li,
    input  logic          Ei,
    input  logic          Lj,
    input  logic          Ej,
    input  logic          EA,
    input  logic          EB,
    input  logic          Bout,
    input  logic          Csel,
    input  logic          Wr,
    output logic          AgtB,
    output logic          zi,
    output logic          zj,
    input  logic          host_sel,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata
);

    localparam logic [AW-1:0] IDX_LAST   = AW'(K - 1);
    localparam logic [AW-1:0] IDX_PENULT = AW'(K - 2);
    // One bit wider than the address so that K itself is representable
    // even when K is a power of two.
    localparam logic [AW:0]   K_WIDE     = (AW + 1)'(K);

    logic [AW-1:0] i_q, i_d;
    logic [AW-1:0] j_q, j_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;

    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_rdata;
    logic [DW-1:0] eng_wdata;
    logic          host_in_range;
    logic [DW-1:0] host_word;

    logic [DW-1:0] mem_rd [K];

    // ------------------------------------------------------------------
    // Address / data muxes
    // ------------------------------------------------------------------
    assign eng_addr      = Csel ? j_q : i_q;
    assign eng_wdata     = Bout ? b_q : a_q;
    assign host_in_range = ({1'b0, host_addr} < K_WIDE);

    // Read muxes are built as explicit compare loops so a non-power-of-two
    // K never indexes past the end of the array.
    always_comb begin
        eng_rdata = '0;
        host_word = '0;
        for (int k = 0; k < K; k++) begin
            if (eng_addr == AW'(k)) begin
                eng_rdata = mem_rd[k];
            end
            if (host_addr == AW'(k)) begin
                host_word = mem_rd[k];
            end
        end
    end

    assign host_rdata = host_in_range ? host_word : '0;

    // ------------------------------------------------------------------
    // Memory: one register per word so reset clears every entry. Reads
    // are combinational, so EA/EB in the same cycle as a write to the
    // same address see the pre-write value.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_word
            logic          we_eng;
            logic          we_host;
            logic [DW-1:0] word_q;

            // The two writers are mutually exclusive through host_sel.
            assign we_eng  = Wr && !host_sel && (eng_addr == AW'(gi));
            assign we_host = host_we && host_sel && host_in_range
                             && (host_addr == AW'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_q <= '0;
                end else if (we_host) begin
                    word_q <= host_wdata;
                end else if (we_eng) begin
                    word_q <= eng_wdata;
                end
            end

            assign mem_rd[gi] = word_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Counters and operand registers: next state
    // ------------------------------------------------------------------
    always_comb begin
        i_d = i_q;
        if (Li) begin
            i_d = '0;
        end else if (Ei) begin
            i_d = (i_q == IDX_LAST) ? '0 : i_q + AW'(1);
        end
    end

    // Lj uses the pre-edge i, so Li and Lj together still give j = old i+1.
    always_comb begin
        j_d = j_q;
        if (Lj) begin
            j_d = (i_q == IDX_LAST) ? '0 : i_q + AW'(1);
        end else if (Ej) begin
            j_d = (j_q == IDX_LAST) ? '0 : j_q + AW'(1);
        end
    end

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (EA) begin
            a_d = eng_rdata;
        end
        if (EB) begin
            b_d = eng_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q <= '0;
            j_q <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    // ------------------------------------------------------------------
    // Status flags, purely from registered state
    // ------------------------------------------------------------------
    assign AgtB = (a_q > b_q);
    assign zi   = (i_q == IDX_PENULT);
    assign zj   = (j_q == IDX_LAST);

endmodule
